fir_capture: RTL and testbench

Output-side capture block for the pipelined FIR datapath. It consumes the filter's `output_signal` stream at one sample per clock and discards a programmable number of leading samples to cover pipeline latency and fill-up. It then stores `DEPTH` consecutive samples in an internal buffer, tracks the peak magnitude, and exposes the buffer through a registered sequential read port. It is the reader for the filter output, the counterpart to the sample writer that drives `input_signal`.

---
 rtl/fir_capture.sv | 142 ++++++++++++++
 tb/tb_fir_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_capture.sv
// fir_capture: output-side capture block for the pipelined FIR datapath.
// After a start request it discards a programmable number of leading samples,
// then stores DEPTH consecutive samples and tracks their peak magnitude. The
// stored samples are read back through a registered sequential read port.
//
// Read handshake: rd_en is a request. It is accepted only in DONE while the
// read pointer is below count. An accepted request returns rd_data with a
// single-cycle rd_valid pulse after the next edge. A request that is not
// accepted leaves rd_valid low and rd_data unchanged. There is no
// backpressure on the read side.
module fir_capture #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        skip_cycles,
   input  logic [DATA_W-1:0] sample_in,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] peak,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [1:0]        fsm_state
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [DATA_W:0] MAX_POS = {2'b00, {(DATA_W-1){1'b1}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         skip_cnt;
   logic [CNT_W-1:0]   rd_ptr;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic [DATA_W:0]    ext;
   logic [DATA_W:0]    mag;
   logic [DATA_W:0]    mag_sat;
   logic [DATA_W-1:0]  peak_next;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W-1:0]  rd_addr;
   logic               rd_ok;

   assign fsm_state = state;

   // Buffer writes happen only on capture edges; a start on the same edge wins.
   assign wr_en   = (state == CAPTURE) && !start;
   assign wr_addr = count[ADDR_W-1:0];
   assign rd_addr = rd_ptr[ADDR_W-1:0];
   assign rd_ok   = (state == DONE) && rd_en && (rd_ptr < count);

   // Magnitude of the incoming sample at DATA_W+1 bits, saturated so the most
   // negative value still fits the unsigned DATA_W peak field.
   always_comb begin
      ext       = {sample_in[DATA_W-1], sample_in};
      mag       = ext;
      if (ext[DATA_W]) begin
         mag = ~ext + (DATA_W+1)'(1);
      end
      mag_sat   = (mag > MAX_POS) ? MAX_POS : mag;
      peak_next = peak;
      if (mag_sat > {1'b0, peak}) begin
         peak_next = mag_sat[DATA_W-1:0];
      end
   end

   // Capture buffer storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= sample_in;
      end
   end

   // Control FSM with registered status, counters, peak and read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         skip_cnt <= '0;
         count    <= '0;
         peak     <= '0;
         rd_ptr   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (start) begin
            skip_cnt <= skip_cycles;
            count    <= '0;
            peak     <= '0;
            rd_ptr   <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= (skip_cycles != 8'd0) ? SKIP : CAPTURE;
         end else begin
            case (state)
               IDLE: begin
                  busy <= 1'b0;
               end
               SKIP: begin
                  skip_cnt <= skip_cnt - 8'd1;
                  if (skip_cnt == 8'd1) begin
                     state <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  count <= count + CNT_W'(1);
                  peak  <= peak_next;
                  if (count == CNT_W'(DEPTH - 1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               DONE: begin
                  if (rd_ok) begin
                     rd_data  <= mem[rd_addr];
                     rd_valid <= 1'b1;
                     rd_ptr   <= rd_ptr + CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fir_capture.sv
// tb_fir_capture: randomized bench for fir_capture with a sample-stream
// reference model (discard S samples after start, keep the next DEPTH).
module tb_fir_capture;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst;
   logic              start;
   logic [7:0]        skip_cycles;
   logic [DATA_W-1:0] sample_in;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] peak;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [1:0]        fsm_state;

   int checks = 0;
   int errors = 0;

   // Reference model state: expected buffer contents and running peak.
   logic [DATA_W-1:0] exp_q[$];
   int                peak_m;
   int                cap_n;
   logic [DATA_W-1:0] last_rd;

   fir_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .skip_cycles(skip_cycles),
      .sample_in(sample_in), .busy(busy), .done(done), .count(count),
      .peak(peak), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fsm_state(fsm_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_abs(input logic [DATA_W-1:0] x);
      int v;
      v = int'($signed(x));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] rand_small();
      return DATA_W'(int'($urandom_range(0, 4000)) - 2000);
   endfunction

   // Sample generators: k counts samples from edge E0+1.
   function automatic logic [DATA_W-1:0] gen(input int mode, input int k, input int s);
      case (mode)
         1: return DATA_W'(k + 1);
         2: begin
            case (k)
               0: return DATA_W'(-5);
               1: return DATA_W'(7);
               2: return DATA_W'(-9);
               3: return DATA_W'(0);
               default: return rand_small();
            endcase
         end
         3: begin
            if (k == s + 2) return 16'h8000;
            if (k == s + 5) return DATA_W'(32000);
            return rand_small();
         end
         default: return DATA_W'($urandom);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_count"}, 32'(count), 0);
      check({tag, "_peak"}, 32'(peak), 0);
      check({tag, "_rd_data"}, 32'(rd_data), 0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 0);
   endtask

   // Driver: the start edge E0. The sample presented here is never captured.
   task automatic start_run(input int s);
      start       = 1'b1;
      skip_cycles = 8'(s);
      sample_in   = DATA_W'($urandom);
      tick();
      start = 1'b0;
      exp_q.delete();
      peak_m = 0;
      cap_n  = 0;
      check("start_busy", 32'(busy), 1);
      check("start_done", 32'(done), 0);
      check("start_count", 32'(count), 0);
      check("start_peak", 32'(peak), 0);
      check("start_rd_valid", 32'(rd_valid), 0);
   endtask

   // Feed s discarded samples then ncap captured ones, checking every edge.
   task automatic capture_phase(input int s, input int mode, input int ncap);
      logic [DATA_W-1:0] v;
      for (int k = 0; k < s + ncap; k++) begin
         v = gen(mode, k, s);
         sample_in = v;
         tick();
         if (k >= s) begin
            exp_q.push_back(v);
            cap_n++;
            if (sat_abs(v) > peak_m) peak_m = sat_abs(v);
         end
         check("run_count", 32'(count), 32'(cap_n));
         check("run_peak", 32'(peak), 32'(peak_m));
         check("run_busy", 32'(busy), (cap_n == DEPTH) ? 0 : 1);
         check("run_done", 32'(done), (cap_n == DEPTH) ? 1 : 0);
         check("run_rd_valid", 32'(rd_valid), 0);
      end
   endtask

   // Scoreboard drain: n back-to-back reads against the expected queue.
   task automatic read_burst(input int n);
      logic [DATA_W-1:0] e;
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         tick();
         check("rd_valid", 32'(rd_valid), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(e));
            last_rd = e;
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic read_exhausted();
      rd_en = 1'b1;
      tick();
      check("rd_extra_valid", 32'(rd_valid), 0);
      check("rd_extra_hold", 32'(rd_data), 32'(last_rd));
      rd_en = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero(tag);
      #2;
      rst = 1'b0;
      tick();
      check_all_zero({tag, "_after"});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; skip_cycles = '0; sample_in = '0; rd_en = 1'b0;
      last_rd = '0; peak_m = 0; cap_n = 0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check_all_zero("idle");

      // Basic ramp run: skip 3, capture 4..19.
      start_run(3);
      capture_phase(3, 1, DEPTH);
      check("basic_peak", 32'(peak), 19);
      read_burst(DEPTH);
      read_exhausted();

      // Zero skip with signed pattern.
      start_run(0);
      capture_phase(0, 2, DEPTH);
      read_burst(DEPTH);
      read_exhausted();

      // Saturation window.
      start_run(4);
      capture_phase(4, 3, DEPTH);
      check("sat_peak", 32'(peak), 32767);
      read_burst(DEPTH);

      // Restart mid-capture at count 5 with skip 2.
      start_run(4);
      capture_phase(4, 0, 5);
      start_run(2);
      capture_phase(2, 0, DEPTH);
      read_burst(DEPTH);
      read_exhausted();

      // Reads held during SKIP and CAPTURE are ignored; first read is buf[0].
      rd_en = 1'b1;
      start_run(5);
      rd_en = 1'b1;
      capture_phase(5, 0, DEPTH);
      read_burst(DEPTH);

      // Start together with rd_en in DONE: start wins.
      start = 1'b1;
      rd_en = 1'b1;
      skip_cycles = 8'd1;
      sample_in = DATA_W'($urandom);
      tick();
      start = 1'b0;
      rd_en = 1'b0;
      check("start_rd_valid_drop", 32'(rd_valid), 0);
      check("start_rd_busy", 32'(busy), 1);
      exp_q.delete();
      peak_m = 0;
      cap_n  = 0;
      capture_phase(1, 0, DEPTH);
      read_burst(DEPTH);

      // Reset during capture.
      start_run(2);
      capture_phase(2, 0, 6);
      async_reset("rst_cap");
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_cap_rd_valid", 32'(rd_valid), 0);
      end
      rd_en = 1'b0;

      // Reset during a read burst.
      start_run($urandom_range(0, 6));
      capture_phase(int'(skip_cycles), 0, DEPTH);
      read_burst(5);
      async_reset("rst_rd");
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_rd_valid", 32'(rd_valid), 0);
      end
      rd_en = 1'b0;

      // A few random runs after recovery.
      for (int r = 0; r < 4; r++) begin
         int s;
         s = $urandom_range(0, 9);
         start_run(s);
         capture_phase(s, 0, DEPTH);
         read_burst(DEPTH);
         read_exhausted();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
